// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle synchronous
// instruction memory, buffers returned words with their PC in a prefetch FIFO, and
// presents the FIFO head to the core over a valid/ready handshake. A redirect flushes
// the FIFO and restarts fetch at the target.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic          Clock,
  input  logic          Reset_n,
  output logic          imem_rd_en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e         state_q;
  logic [31:0]    pc_q;
  logic [31:0]    fetch_pc_q;
  logic           inflight_q;
  logic           squash_q;
  logic [CW-1:0]  count_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW-1:0]  wr_ptr_q;
  logic [31:0]    fifo_instr_q [FIFO_DEPTH];
  logic [31:0]    fifo_pc_q    [FIFO_DEPTH];

  logic [CW:0]    occupancy;
  logic           credit_ok;
  logic           issue;
  logic           push;
  logic           head_valid;
  logic           pop;

  // Credits count both buffered and in-flight words; a pop this cycle is not credited.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    credit_ok  = occupancy < (CW + 1)'(FIFO_DEPTH);
    issue      = Reset_n & ~redirect_valid & credit_ok;
    push       = Reset_n & inflight_q & ~squash_q & ~redirect_valid;
    head_valid = (count_q != '0);
    pop        = Reset_n & head_valid & instr_ready;
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    imem_rd_en  = issue;
    imem_addr   = pc_q[AW+1:2];
    instr_valid = Reset_n & head_valid;
    instr       = Reset_n ? fifo_instr_q[rd_ptr_q] : 32'h0;
    instr_pc    = Reset_n ? fifo_pc_q[rd_ptr_q] : 32'h0;
  end

  // PC, read pipeline, FIFO bookkeeping and RUN/FLUSH state.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        fetch_pc_q <= pc_q;
        pc_q       <= pc_q + 32'd4;
      end
      if (redirect_valid) begin
        // Any read issued alongside the redirect must not land in the new stream.
        state_q  <= StFlush;
        squash_q <= issue;
        pc_q     <= {redirect_pc[31:2], 2'b00};
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        state_q  <= StRun;
        squash_q <= 1'b0;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        unique case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // FIFO storage; data entries need no reset because count gates visibility.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  // Credit scheme must never let the FIFO overflow.
  count_bound_a : assert property (@(posedge Clock) disable iff (!Reset_n)
                                   count_q <= CW'(FIFO_DEPTH));

  logic unused_ok;
  assign unused_ok = ^{redirect_pc[1:0], state_q};

endmodule
